// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree and its operand loader.
// Holds width/leaf-count defaults, index width and the loader state encoding.
package adder_tree_pkg;
  localparam int ADDER_WIDTH_DEF  = 64;
  localparam int NUM_OPERANDS_DEF = 8;
  localparam int IDX_W            = $clog2(NUM_OPERANDS_DEF);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;
endpackage

// File: rtl/adder_tree_operand_loader.sv
// Collects operands from a valid/ready stream into batches for the adder tree.
// A fill buffer assembles the next batch while a shadow register holds the current one.
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DEF,
  parameter int NUM_OPERANDS = NUM_OPERANDS_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ADDER_WIDTH-1:0]              in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] op_bus,
  output logic [$clog2(NUM_OPERANDS):0]       op_count,
  output logic                                op_valid,
  input  logic                                op_ready
);

  localparam int IW = $clog2(NUM_OPERANDS);
  localparam int CW = IW + 1;
  localparam int BW = NUM_OPERANDS * ADDER_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPERANDS - 1);

  state_e         state, state_nx;
  logic [BW-1:0]  fill_q;
  logic [BW-1:0]  fill_wr;
  logic [IW-1:0]  idx_q;
  logic           accept;
  logic           close;
  logic           shadow_free;
  logic           out_xfer;
  logic           load_shadow;
  logic [BW-1:0]  load_bus;
  logic [CW-1:0]  load_cnt;

  assign accept      = in_valid && in_ready;
  assign close       = accept && ((idx_q == LAST_IDX) || in_last);
  assign out_xfer    = op_valid && op_ready;
  assign shadow_free = !op_valid || op_ready;

  // Lane-write decoder: fill buffer with the incoming word placed at idx.
  always_comb begin
    fill_wr = fill_q;
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      if (idx_q == IW'(i)) begin
        fill_wr[i*ADDER_WIDTH +: ADDER_WIDTH] = in_data;
      end
    end
  end

  // In FULL the closing word is already in fill_q and idx still points at it.
  assign load_bus = (state == FULL) ? fill_q : fill_wr;
  assign load_cnt = CW'(idx_q) + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (close && !shadow_free) state_nx = FULL;
      FULL:    if (shadow_free)           state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    load_shadow = 1'b0;
    case (state)
      FILL: begin
        in_ready    = 1'b1;
        load_shadow = close && shadow_free;
      end
      FULL: begin
        load_shadow = shadow_free;
      end
      default: begin
        in_ready    = 1'b0;
        load_shadow = 1'b0;
      end
    endcase
  end

  // Fill buffer and index; lanes clear on every handoff so short batches zero-pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      idx_q  <= '0;
    end else if (load_shadow) begin
      fill_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      fill_q <= fill_wr;
      if (!close) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  // Shadow register: bus and count only move on a load, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_bus   <= '0;
      op_count <= '0;
      op_valid <= 1'b0;
    end else if (load_shadow) begin
      op_bus   <= load_bus;
      op_count <= load_cnt;
      op_valid <= 1'b1;
    end else if (out_xfer) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Scoreboard bench for adder_tree_operand_loader: directed batches plus throttled traffic.
module tb_adder_tree_operand_loader;
  import adder_tree_pkg::*;

  localparam int AW = 64;
  localparam int N  = 8;
  localparam int CW = IDX_W + 1;
  localparam int BW = N * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [BW-1:0] op_bus;
  logic [CW-1:0] op_count;
  logic          op_valid;
  logic          op_ready = 1'b0;

  typedef struct {
    logic [BW-1:0] bus;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  bit rnd_mode = 1'b0;
  bit model_on = 1'b0;
  logic [AW-1:0] ml[N];
  int midx = 0;

  adder_tree_operand_loader #(.ADDER_WIDTH(AW), .NUM_OPERANDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .op_bus(op_bus),
    .op_count(op_count), .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [BW-1:0] seq_bus(input logic [AW-1:0] start, input int n);
    logic [BW-1:0] b = '0;
    for (int i = 0; i < n; i++) b[i*AW +: AW] = start + AW'(i);
    return b;
  endfunction

  task automatic push_exp(input logic [BW-1:0] b, input int c);
    exp_t e;
    e.bus = b;
    e.cnt = CW'(c);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) op_ready = ($urandom_range(0, 2) != 0);
  endtask

  // Idle cycle with in_last raised to show it is ignored without in_valid.
  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b1;
    tick();
    in_last  = 1'b0;
  endtask

  task automatic model_word(input logic [AW-1:0] d, input logic last);
    logic [BW-1:0] b;
    ml[midx] = d;
    if (midx == N - 1 || last) begin
      b = '0;
      for (int i = 0; i <= midx; i++) b[i*AW +: AW] = ml[i];
      push_exp(b, midx + 1);
      midx = 0;
    end else begin
      midx++;
    end
  endtask

  task automatic send_word(input logic [AW-1:0] d, input logic last);
    int waited = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
    end else begin
      tick();
      if (model_on) model_word(d, last);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    op_ready = 1'b1;
    repeat (3) idle();
  endtask

  // Monitor: pops on every output transfer and checks bus stability under backpressure.
  initial begin : monitor
    logic          hold = 1'b0;
    logic [BW-1:0] pbus;
    logic [CW-1:0] pcnt;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_bus", op_bus, pbus);
          chk("hold_cnt", BW'(op_count), BW'(pcnt));
        end
        if (op_valid && op_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_batch: got count %0d with no batch expected", op_count);
          end else begin
            e = exp_q.pop_front();
            chk("batch_bus", op_bus, e.bus);
            chk("batch_cnt", BW'(op_count), BW'(e.cnt));
          end
        end
        hold = op_valid && !op_ready;
        pbus = op_bus;
        pcnt = op_count;
      end
    end
  end

  initial begin : stim
    logic [BW-1:0] b;
    #2;
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_valid", BW'(op_valid), BW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_bus", op_bus, '0);
    chk("rst_cnt", BW'(op_count), BW'(0));
    chk("rst_in_ready_after", BW'(in_ready), BW'(1));

    // Full batch 1..8 with the consumer ready.
    op_ready = 1'b1;
    stalls = 0;
    push_exp(seq_bus(64'd1, 8), 8);
    for (int i = 1; i <= 7; i++) send_word(AW'(i), 1'b0);
    chk("t1_not_yet_valid", BW'(op_valid), BW'(0));
    send_word(64'd8, 1'b0);
    chk("t1_valid", BW'(op_valid), BW'(1));
    chk("t1_bus", op_bus, seq_bus(64'd1, 8));
    chk("t1_cnt", BW'(op_count), BW'(8));
    chk("t1_no_stall", BW'(stalls), BW'(0));
    drain();

    // Two back-to-back batches 9..16 and 17..24.
    stalls = 0;
    push_exp(seq_bus(64'd9, 8), 8);
    push_exp(seq_bus(64'd17, 8), 8);
    for (int i = 9; i <= 16; i++) send_word(AW'(i), 1'b0);
    chk("t2_first_valid", BW'(op_valid), BW'(1));
    for (int i = 17; i <= 24; i++) send_word(AW'(i), 1'b0);
    chk("t2_second_valid", BW'(op_valid), BW'(1));
    chk("t2_second_bus", op_bus, seq_bus(64'd17, 8));
    chk("t2_no_stall", BW'(stalls), BW'(0));
    drain();

    // Backpressure: second batch stalls in FULL until op_ready rises.
    op_ready = 1'b0;
    stalls = 0;
    push_exp(seq_bus(64'h21, 8), 8);
    push_exp(seq_bus(64'h29, 8), 8);
    for (int i = 0; i < 16; i++) send_word(64'h21 + AW'(i), 1'b0);
    chk("t3_in_ready_low", BW'(in_ready), BW'(0));
    chk("t3_held_bus", op_bus, seq_bus(64'h21, 8));
    chk("t3_no_stall_on_fill", BW'(stalls), BW'(0));
    repeat (3) tick();
    chk("t3_still_full", BW'(in_ready), BW'(0));
    op_ready = 1'b1;
    tick();
    chk("t3_second_valid", BW'(op_valid), BW'(1));
    chk("t3_second_bus", op_bus, seq_bus(64'h29, 8));
    chk("t3_in_ready_back", BW'(in_ready), BW'(1));
    drain();

    // Short batches closed by in_last.
    b = '0;
    b[0*AW +: AW] = 64'hA;
    b[1*AW +: AW] = 64'hB;
    b[2*AW +: AW] = 64'hC;
    push_exp(b, 3);
    push_exp(seq_bus(64'hD, 1), 1);
    send_word(64'hA, 1'b0);
    idle();
    send_word(64'hB, 1'b0);
    send_word(64'hC, 1'b1);
    chk("t4_short_bus", op_bus, b);
    chk("t4_short_cnt", BW'(op_count), BW'(3));
    send_word(64'hD, 1'b1);
    chk("t4_single_bus", op_bus, seq_bus(64'hD, 1));
    chk("t4_single_cnt", BW'(op_count), BW'(1));
    drain();

    // Reset with a batch in the shadow and a partial fill.
    op_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(64'h41 + AW'(i), 1'b0);
    for (int i = 0; i < 5; i++) send_word(64'h51 + AW'(i), 1'b0);
    chk("t5_pending_valid", BW'(op_valid), BW'(1));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_rst_valid", BW'(op_valid), BW'(0));
    chk("t5_rst_bus", op_bus, '0);
    chk("t5_rst_in_ready", BW'(in_ready), BW'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op_ready = 1'b1;
    push_exp(seq_bus(64'h61, 8), 8);
    for (int i = 0; i < 7; i++) send_word(64'h61 + AW'(i), 1'b0);
    chk("t5_no_leftover", BW'(op_valid), BW'(0));
    send_word(64'h68, 1'b0);
    chk("t5_clean_bus", op_bus, seq_bus(64'h61, 8));
    chk("t5_clean_cnt", BW'(op_count), BW'(8));
    drain();

    // Throttled traffic, 1000 words, checked through the model and monitor.
    rnd_mode = 1'b1;
    model_on = 1'b1;
    midx = 0;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) idle();
      send_word(64'h5000_0000 + AW'(n), ($urandom_range(0, 9) == 0));
    end
    if (midx != 0) send_word(64'h5FFF_FFFF, 1'b1);
    rnd_mode = 1'b0;
    model_on = 1'b0;
    op_ready = 1'b1;
    repeat (10) idle();
    chk("sb_drained", BW'(exp_q.size()), BW'(0));
    chk("end_valid_low", BW'(op_valid), BW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_operand_loader.md
# adder_tree_operand_loader

Upstream feeder for the 3-level adder tree. It accepts one ADDER_WIDTH-bit operand per cycle over a valid/ready stream and assembles batches of NUM_OPERANDS operands. It presents each batch as a flat, stable parallel bus with its own valid/ready handshake; the bus drives the tree's isum lanes. Double-buffered: a new batch fills while the previous one waits for the consumer.

## Interface
Parameters:
- ADDER_WIDTH, 64, operand width; equals the tree's ADDER_WIDTH.
- NUM_OPERANDS, 8, operands per batch; equals the tree's leaf count (2^levels).

Ports:
- clk  in  1  sole clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  ADDER_WIDTH  operand word.
- in_valid  in  1  in_data valid.
- in_last  in  1  final word of a short batch; qualified by in_valid.
- in_ready  out  1  loader accepts a word this cycle.
- op_bus  out  NUM_OPERANDS*ADDER_WIDTH  lane i at bits [i*ADDER_WIDTH +: ADDER_WIDTH]; lane 0 → isum0_0_0_0, lane 7 → isum0_1_1_1.
- op_count  out  clog2(NUM_OPERANDS)+1  number of real operands in op_bus (1..NUM_OPERANDS).
- op_valid  out  1  op_bus/op_count hold a complete batch.
- op_ready  in  1  consumer takes the batch this cycle.

## Operation
- A word transfers when in_valid && in_ready; an output batch transfers when op_valid && op_ready.
- Fill buffer: NUM_OPERANDS lanes plus fill index idx (0..NUM_OPERANDS-1). Each accepted word is written to lane idx.
- A batch closes when a word is accepted with idx == NUM_OPERANDS-1, or with in_last = 1.
- Lanes above the closing index are zero in the closed batch. op_count = closing idx + 1.
- Shadow register: drives op_bus, op_count and op_valid.
- FSM states:
  - FILL: in_ready = 1. On batch close:
    - If shadow is free (op_valid = 0, or an output transfer happens this cycle), the batch, including the closing word, loads into the shadow at the same edge. op_valid = 1, idx = 0, and the state stays FILL.
    - Otherwise go to FULL.
  - FULL: in_ready = 0 and the fill buffer is held. When the shadow frees (op_valid = 0, or an output transfer this cycle), move the fill buffer to the shadow, set op_valid = 1, clear the fill buffer to zero, set idx = 0 and return to FILL.
- Fill buffer lanes are cleared to zero whenever a batch moves to the shadow.
- op_valid falls after an output transfer with no new batch loading in the same cycle.
- op_bus and op_count hold their last value while op_valid = 0. They never change while op_valid && !op_ready.
- in_last is ignored when in_valid = 0.
- in_ready depends only on state (no combinational path from op_ready).

## Timing
- Reset (async assert, sync release): state FILL, idx 0, fill buffer 0, op_bus 0, op_count 0, op_valid 0. in_ready = 1 while and after reset.
- Latency: closing word accepted at edge k → op_valid = 1 in the cycle after edge k.
- Throughput: one word per cycle sustained when op_ready is held high. No bubbles between batches.
- Backpressure: a second batch closing while the shadow is occupied costs one FULL stall until op_ready.
- Simultaneous input close and output transfer in the same cycle: the new batch replaces the shadow at that edge and op_valid stays 1.
- Reset mid-batch discards the partial fill and the shadow contents.
- The tree samples its inputs every clk. The integrating wrapper gates on op_valid; the loader's only guarantee is op_bus stability.

## Structure
- Shared package adder_tree_pkg holds:
  - ADDER_WIDTH and NUM_OPERANDS defaults.
  - IDX_W = clog2(NUM_OPERANDS).
  - state enum {FILL, FULL}.
- No sub-module. A single module containing the lane-write decoder, the index counter, the FSM and the shadow register.

## Test plan
- Reset, then 8 words 1..8 with op_ready = 1 → op_valid high one cycle after word 8, with lanes 0..7 = 1..8, op_count = 8, in_ready never low.
- 16 back-to-back words with op_ready = 1 → two batches on consecutive 8-cycle boundaries (1..8, then 9..16) and no in_ready deassertion.
- op_ready = 0, 16 words → first batch held stable, in_ready low after word 16. Raise op_ready → the second batch appears next cycle and in_ready returns high.
- Words 0xA, 0xB, 0xC with in_last on 0xC → lanes 0..2 = A, B, C, lanes 3..7 = 0, op_count = 3. A following single word with in_last gives op_count = 1 and lanes 1..7 = 0.
- Assert rst_n low after 5 words with a batch pending in the shadow → op_valid = 0 and op_bus = 0 immediately. Next 8 words form a clean batch with no leftovers.
- Random in_valid/op_ready throttling, 1000 words → scoreboard: every word appears exactly once, in order, in the correct lane; op_bus never changes while op_valid && !op_ready.
